// File: rtl/vbus_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vbus_tx_sequencer
// Purpose  : Buffers (select, data) words and presents each on one of NUM_BUS
//            valid/ready output groups, dropping words on timeout or when the
//            select is out of range.
// Revision : 1.0 - initial release
// ============================================================================
module vbus_tx_sequencer #(
  parameter int DATA_W     = 8,
  parameter int NUM_BUS    = 4,
  parameter int SEL_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SEL_W-1:0]          s_sel,
  input  logic [DATA_W-1:0]         s_data,
  output logic [NUM_BUS-1:0]        vb_valid,
  input  logic [NUM_BUS-1:0]        vb_ready,
  output logic [NUM_BUS*DATA_W-1:0] vb_data,
  output logic                      err_timeout,
  output logic                      err_badsel,
  output logic [SEL_W-1:0]          err_bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int ENT_W = SEL_W + DATA_W;

  localparam logic [AW:0]      c_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [SEL_W:0]   c_NUM_BUS  = (SEL_W+1)'(NUM_BUS);
  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] c_TMO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // ---------------- input FIFO ----------------
  logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              s_ready_q;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;
  logic [SEL_W-1:0]  w_head_sel;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_ok;

  // s_ready is the registered not-full flag, so a same-cycle pop never
  // opens a slot for a push.
  assign w_push      = s_valid && s_ready_q;
  assign s_ready     = s_ready_q;
  assign w_empty     = (count_q == '0);
  assign w_head      = fifo_mem_q[rd_ptr_q];
  assign w_head_sel  = w_head[ENT_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_head_ok   = ({1'b0, w_head_sel} < c_NUM_BUS);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= {s_sel, s_data};
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      s_ready_q <= (count_d != c_DEPTH);
    end
  end

  // ---------------- output register and sequencer ----------------
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_timeout_q;
  logic               err_badsel_q;
  logic [SEL_W-1:0]   err_bus_q;

  logic [NUM_BUS-1:0] w_onehot;
  logic               w_hs;
  logic               w_tmo_hit;
  logic               w_load;
  logic               w_badsel;
  logic               w_tmo;

  // Only the active lane carries data; everything else is forced to zero.
  for (genvar i = 0; i < NUM_BUS; i++) begin : g_lane
    assign w_onehot[i] = (state_q == ST_PRESENT) && (sel_q == SEL_W'(i));
    assign vb_data[i*DATA_W +: DATA_W] = w_onehot[i] ? data_q : '0;
  end

  assign vb_valid    = w_onehot;
  assign w_hs        = |(w_onehot & vb_ready);
  assign w_tmo_hit   = (TIMEOUT != 0) && (cnt_q == c_TMO_LAST);
  assign err_timeout = err_timeout_q;
  assign err_badsel  = err_badsel_q;
  assign err_bus     = err_bus_q;

  // Next state: pop/load/drop decisions; a handshake always beats a timeout.
  always_comb begin
    state_d  = state_q;
    w_pop    = 1'b0;
    w_load   = 1'b0;
    w_badsel = 1'b0;
    w_tmo    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_ok) begin
            w_load  = 1'b1;
            state_d = ST_PRESENT;
          end else begin
            w_badsel = 1'b1;
          end
        end
      end
      ST_PRESENT: begin
        if (w_hs) begin
          if (!w_empty) begin
            w_pop = 1'b1;
            if (w_head_ok) begin
              w_load = 1'b1;
            end else begin
              w_badsel = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_tmo   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, presented word, saturating wait counter and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_badsel_q  <= 1'b0;
      err_bus_q     <= '0;
    end else begin
      state_q <= state_d;
      if (w_load) begin
        sel_q  <= w_head_sel;
        data_q <= w_head_data;
        cnt_q  <= '0;
      end else if ((state_q == ST_PRESENT) && !w_hs && (cnt_q < c_TMO_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      err_timeout_q <= w_tmo;
      err_badsel_q  <= w_badsel;
      if (w_badsel)   err_bus_q <= w_head_sel;
      else if (w_tmo) err_bus_q <= sel_q;
    end
  end

endmodule
`default_nettype wire
